// File: rtl/exibidor_pkg.sv
// Shared definitions for the sequence playback engine: state encoding,
// default timing constants and a small helper used by the tone generator.
package exibidor_pkg;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        ENDERECA = 3'd1,
        CAPTURA  = 3'd2,
        ACESO    = 3'd3,
        APAGADO  = 3'd4,
        FIM      = 3'd5
    } estadoT;

    localparam int ON_CYCLES_DEF  = 5000;
    localparam int OFF_CYCLES_DEF = 2500;
    localparam int TOM_BASE_DEF   = 4;

    // Index of the highest set bit; 0 for an all-zero value.
    function automatic logic [1:0] bitMaisAlto(input logic [3:0] valor);
        logic [1:0] p;
        p = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (valor[i]) begin
                p = 2'(i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/exibidor_sequencia_gerador_tom.sv
// Square-wave tone generator for the buzzer. While enabled with a non-zero
// value, the output toggles every TOM_BASE*(p+1) cycles, where p is the
// highest set bit of the value. Dropping enable clears the divider, so each
// new lit window starts the tone from a known phase.
module gerador_tom
    import exibidor_pkg::*;
#(
    parameter int TOM_BASE = TOM_BASE_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] valor,
    output logic       pulso
);

    localparam int MAX_HALF = TOM_BASE * 4;
    localparam int CW       = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;

    logic [CW-1:0] contagem;
    logic [CW-1:0] limite;
    logic          nivel;
    logic          ativo;

    // Last count of the current half-period, derived from the entry value.
    always_comb begin
        limite = CW'(TOM_BASE * (int'(bitMaisAlto(valor)) + 1) - 1);
        ativo  = enable && (valor != 4'd0);
    end

    // Divider: count up to the half-period limit, then flip the output level.
    always_ff @(posedge clock) begin
        if (!reset || !ativo) begin
            contagem <= '0;
            nivel    <= 1'b0;
        end else if (contagem == limite) begin
            contagem <= '0;
            nivel    <= ~nivel;
        end else begin
            contagem <= contagem + 1'b1;
        end
    end

    assign pulso = nivel & ativo;

endmodule

// File: rtl/exibidor_sequencia.sv
// Playback engine for the memory game. On request it walks the game RAM from
// address 0 to the latched last index, lighting each entry for ON_CYCLES and
// then going dark for OFF_CYCLES, and pulses pronto when the sequence is done.
// Optional buzzer tone is built only when EXIBIDOR_BUZZER_EN is defined;
// otherwise pulso_buzzer is tied low.
module exibidor_sequencia
    import exibidor_pkg::*;
#(
    parameter int ON_CYCLES  = ON_CYCLES_DEF,
    parameter int OFF_CYCLES = OFF_CYCLES_DEF,
    parameter int TOM_BASE   = TOM_BASE_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       cancela,
    input  logic [3:0] ultimo,
    output logic [3:0] mem_addr,
    input  logic [3:0] mem_data,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic       pulso_buzzer,
    output logic [2:0] db_estado
);

    localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(OFF_CYCLES - 1);

    if (ON_CYCLES < 1 || OFF_CYCLES < 1 || TOM_BASE < 1) begin : gParamInvalido
        $error("exibidor_sequencia: ON_CYCLES, OFF_CYCLES and TOM_BASE must all be >= 1");
    end

    estadoT               estado;
    logic [3:0]           indice;
    logic [3:0]           ultimoReg;
    logic [3:0]           dadoReg;
    logic [TIMER_W-1:0]   timer;

    // Playback sequencer: address, capture, lit window, dark gap, repeat until
    // the latched last index, then a one-cycle done state. Abort wins anywhere.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado    <= OCIOSO;
            indice    <= 4'd0;
            ultimoReg <= 4'd0;
            dadoReg   <= 4'd0;
            timer     <= '0;
        end else if (cancela && estado != OCIOSO) begin
            estado <= OCIOSO;
            timer  <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (iniciar && !cancela) begin
                        ultimoReg <= ultimo;
                        indice    <= 4'd0;
                        timer     <= '0;
                        estado    <= ENDERECA;
                    end
                end
                ENDERECA: begin
                    timer  <= '0;
                    estado <= CAPTURA;
                end
                CAPTURA: begin
                    dadoReg <= mem_data;
                    timer   <= '0;
                    estado  <= ACESO;
                end
                ACESO: begin
                    if (timer == ON_LAST) begin
                        timer  <= '0;
                        estado <= APAGADO;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                APAGADO: begin
                    if (timer == OFF_LAST) begin
                        timer <= '0;
                        if (indice == ultimoReg) begin
                            estado <= FIM;
                        end else begin
                            indice <= indice + 4'd1;
                            estado <= ENDERECA;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                FIM: begin
                    timer  <= '0;
                    estado <= OCIOSO;
                end
                default: begin
                    timer  <= '0;
                    estado <= OCIOSO;
                end
            endcase
        end
    end

    assign mem_addr  = indice;
    assign leds      = (estado == ACESO) ? dadoReg : 4'd0;
    assign ocupado   = (estado != OCIOSO);
    assign pronto    = (estado == FIM);
    assign db_estado = estado;

`ifdef EXIBIDOR_BUZZER_EN
    gerador_tom #(
        .TOM_BASE (TOM_BASE)
    ) uGeradorTom (
        .clock  (clock),
        .reset  (reset),
        .enable (estado == ACESO),
        .valor  (dadoReg),
        .pulso  (pulso_buzzer)
    );
`else
    assign pulso_buzzer = 1'b0;
`endif

endmodule

// File: doc/exibidor_sequencia.md
# exibidor_sequencia

Playback engine for the memory game: on request, reads the stored sequence from the synchronous 16x4 game RAM, entry 0 up to a given last index, and presents each entry on the LEDs for a fixed on-time followed by a dark gap, then pulses `pronto`. It is the reader and presenter counterpart of the datapath that captures player moves and writes them into the RAM. It sits between the game controller, which starts it once per round, and the RAM read port and LED/buzzer outputs.

## Interface
- `ON_CYCLES`, 5000: clock cycles each entry stays lit. Must be ≥1.
- `OFF_CYCLES`, 2500: clock cycles dark after each entry. Must be ≥1.
- `TOM_BASE`, 4: buzzer half-period unit, in clock cycles. Used only with the macro.
- `clock`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `iniciar`  input  1  start request; sampled only in OCIOSO.
- `cancela`  input  1  abort; returns to OCIOSO next edge without `pronto`.
- `ultimo`  input  4  last address to show (the round count); registered at start.
- `mem_addr`  output  4  RAM read address.
- `mem_data`  input  4  RAM read data; valid one cycle after `mem_addr` is sampled.
- `leds`  output  4  displayed entry; 0 when dark.
- `ocupado`  output  1  high in every state except OCIOSO.
- `pronto`  output  1  one-cycle pulse at end of a full playback.
- `pulso_buzzer`  output  1  tone square wave.
- `db_estado`  output  3  state encoding, for debug.

## Operation
- States and encodings: OCIOSO=0, ENDERECA=1, CAPTURA=2, ACESO=3, APAGADO=4, FIM=5.
- OCIOSO:
  - If `iniciar=1` and `cancela=0`: `ultimo_reg<=ultimo`, `indice<=0`, timer<=0, go to ENDERECA.
  - If `cancela=1`, stay in OCIOSO. `cancela` wins over `iniciar`.
- ENDERECA: `mem_addr=indice` is stable. Go to CAPTURA.
- CAPTURA: `dado_reg<=mem_data`, timer<=0, go to ACESO.
- ACESO: `leds=dado_reg`.
  - Timer counts from 0 to ON_CYCLES-1.
  - On terminal count: timer<=0, go to APAGADO.
- APAGADO: `leds=0`. Timer counts from 0 to OFF_CYCLES-1. On terminal count:
  - If `indice==ultimo_reg`, go to FIM.
  - Otherwise `indice<=indice+1`, go to ENDERECA.
- FIM: `pronto=1` for this single cycle, then go to OCIOSO.
- `cancela=1` in any state other than OCIOSO: go to OCIOSO next edge. `leds` goes to 0 and `pronto` stays 0.
- `mem_addr` always equals `indice`. `indice` holds its value in OCIOSO.
- Timer width is `$clog2(max(ON_CYCLES,OFF_CYCLES))`, minimum 1. Timer is unsigned and never wraps; it is cleared on every state entry.
- `ultimo` changes during playback are ignored.
- `ultimo=0` shows exactly one entry. `ultimo=15` shows 16 entries; `indice` never wraps because the compare ends playback first.
- An entry value of 0 is still timed in full, with `leds=0`.
- `iniciar` held high through FIM restarts playback on the cycle after FIM.

## Timing
- Reset values: state=OCIOSO, `indice=0`, `dado_reg=0`, timer=0, `leds=0`, `mem_addr=0`, `ocupado=0`, `pronto=0`, `pulso_buzzer=0`, `db_estado=0`.
- Let `iniciar` be sampled at edge k:
  - ENDERECA after k.
  - CAPTURA after k+1.
  - `leds=mem[0]` from edge k+2, through edge k+2+ON_CYCLES.
- Per entry: 2 + ON_CYCLES + OFF_CYCLES cycles.
- Full playback, `iniciar` sample to `pronto`: (ultimo+1)·(2+ON_CYCLES+OFF_CYCLES) + 1 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- Macro `EXIBIDOR_BUZZER_EN`.
- When defined:
  - In ACESO with `dado_reg≠0`, `pulso_buzzer` toggles every TOM_BASE·(p+1) cycles, where p is the index of the highest set bit of `dado_reg`.
  - `pulso_buzzer` is 0 in all other states, and its divider restarts on entry to ACESO.
- When undefined: the port stays present, tied to 0, and no divider logic is built.

## Structure
- Package `exibidor_pkg` holds:
  - the state enum with the encodings above;
  - default constants `ON_CYCLES_DEF=5000`, `OFF_CYCLES_DEF=2500`, `TOM_BASE_DEF=4`.
- One sub-module, `gerador_tom`: inputs are clock, reset, enable and a 4-bit value; output is `pulso`. It is instantiated only under the macro.

## Test plan
- Preload RAM with {3,5,9,0}, ON=4, OFF=2, `ultimo=2`, pulse `iniciar`:
  - `leds` shows 3,0,5,0,9,0, each lit value for 4 cycles and each dark gap for 2 cycles;
  - `pronto` pulses once, 25 cycles after the start sample;
  - `ocupado` is low afterwards.
- `ultimo=0`, RAM[0]=F: one 4-cycle F flash, then `pronto`. Change `ultimo` to 7 mid-run: no effect.
- `cancela` asserted during the second ACESO: OCIOSO next edge, `leds=0`, no `pronto`. `iniciar` plus `cancela` together in OCIOSO: no start.
- `reset=0` for 1 cycle mid-APAGADO: all outputs at their reset values on the following cycle. Pulses of `iniciar` while `ocupado` are ignored.
- `ultimo=15`, RAM[i]=i: addresses 0..15 issued in order, exactly 16 lit windows, `pronto` once.
- With `EXIBIDOR_BUZZER_EN` defined, TOM_BASE=4, entry 4'b0100: `pulso_buzzer` half-period is 12 cycles in ACESO and 0 in APAGADO. Without the macro, `pulso_buzzer` is constantly 0.
